regfile_mp: RTL and testbench

Parametrised multi-port register file for the RISC-V core: generalises the 2-read/1-write integer file to a configurable width, depth and read-port count, with two write ports. Reads are registered with full forwarding, and held read data stays coherent with later writes. A per-register busy scoreboard supports hazard detection. It sits between decode (read/allocate) and writeback (two retire ports).

---
 rtl/regfile_mp_if.sv | 38 +++
 rtl/regfile_mp.sv | 114 +++++++++++
 tb/tb_regfile_mp.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two writeback ports, NRD read ports and the
// decode-side allocation port, plus the scoreboard view.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
);
  logic                 wr0_en;
  logic [AW-1:0]        wr0_index;
  logic [XLEN-1:0]      wr0_data;
  logic                 wr1_en;
  logic [AW-1:0]        wr1_index;
  logic [XLEN-1:0]      wr1_data;
  logic [NRD-1:0]       rd_en;
  logic [NRD*AW-1:0]    rd_index;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 alloc_en;
  logic [AW-1:0]        alloc_index;
  logic [DEPTH-1:0]     busy_vec;

  modport master (
    output wr0_en, wr0_index, wr0_data,
    output wr1_en, wr1_index, wr1_data,
    output rd_en, rd_index,
    output alloc_en, alloc_index,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  wr0_en, wr0_index, wr0_data,
    input  wr1_en, wr1_index, wr1_data,
    input  rd_en, rd_index,
    input  alloc_en, alloc_index,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NRD registered read ports with
// write forwarding and coherent held data, and a per-register busy scoreboard.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         reset_n,
  regfile_mp_if.slave bus
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [XLEN-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             wr0_commit;
  logic             wr1_commit;

  // A write to the hardwired zero entry is enabled but never commits.
  assign wr0_commit = bus.wr0_en && !(ZR && (bus.wr0_index == '0));
  assign wr1_commit = bus.wr1_en && !(ZR && (bus.wr1_index == '0));

  always_comb begin
    mem_d = mem_q;
    if (wr0_commit) mem_d[bus.wr0_index] = bus.wr0_data;
    if (wr1_commit) mem_d[bus.wr1_index] = bus.wr1_data;
  end

  // Set is applied after clear so a same-cycle allocation outlives the write.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if ((wr0_commit && (bus.wr0_index == AW'(i))) ||
          (wr1_commit && (bus.wr1_index == AW'(i))))
        busy_d[i] = 1'b0;
      if (bus.alloc_en && (bus.alloc_index == AW'(i)) && !(ZR && (i == 0)))
        busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign bus.busy_vec = busy_q;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_port
      logic [AW-1:0]   idx;
      logic [AW-1:0]   raddr_q;
      logic [AW-1:0]   raddr_d;
      logic [XLEN-1:0] rdata_q;
      logic [XLEN-1:0] rdata_d;
      logic            hit0;
      logic            hit1;
      logic            zero_hold;

      assign idx       = bus.rd_index[gi*AW +: AW];
      assign hit0      = bus.wr0_en && (bus.wr0_index == raddr_q);
      assign hit1      = bus.wr1_en && (bus.wr1_index == raddr_q);
      assign zero_hold = ZR && (raddr_q == '0);

      // Capture takes the post-write value; otherwise track writes to the held address.
      always_comb begin
        raddr_d = raddr_q;
        rdata_d = rdata_q;
        if (bus.rd_en[gi]) begin
          raddr_d = idx;
          if (ZR && (idx == '0))
            rdata_d = '0;
          else if (bus.wr1_en && (bus.wr1_index == idx))
            rdata_d = bus.wr1_data;
          else if (bus.wr0_en && (bus.wr0_index == idx))
            rdata_d = bus.wr0_data;
          else
            rdata_d = mem_q[idx];
        end else if (wr1_commit && (bus.wr1_index == raddr_q)) begin
          rdata_d = bus.wr1_data;
        end else if (wr0_commit && (bus.wr0_index == raddr_q)) begin
          rdata_d = bus.wr0_data;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          raddr_q <= '0;
          rdata_q <= '0;
        end else begin
          raddr_q <= raddr_d;
          rdata_q <= rdata_d;
        end
      end

      assign bus.rd_data[gi*XLEN +: XLEN] = zero_hold ? '0 :
                                            hit1      ? bus.wr1_data :
                                            hit0      ? bus.wr0_data :
                                                        rdata_q;
      assign bus.rd_busy[gi] = !zero_hold && !hit0 && !hit1 && busy_q[raddr_q];
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with a register-array model compared every cycle.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  bit   run = 1'b0;
  int   checks = 0;
  int   errors = 0;

  regfile_mp_if #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .NRD(NRD)) bus ();

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Model: architectural register values, busy bits and which register each port holds.
  logic [XLEN-1:0]  m_mem [DEPTH];
  logic [DEPTH-1:0] m_busy;
  int               m_haddr [NRD];

  task automatic chk(input string nm, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp, input bit quiet);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end else if (!quiet) begin
      $display("ok   %s value=0x%0h t=%0t", nm, act, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] rd(input int p);
    return bus.rd_data[p*XLEN +: XLEN];
  endfunction

  function automatic bit wr_to(input int a);
    return (bus.wr0_en && (int'(bus.wr0_index) == a)) ||
           (bus.wr1_en && (int'(bus.wr1_index) == a));
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int p);
    int a = m_haddr[p];
    if (a == 0) return '0;
    if (bus.wr1_en && (int'(bus.wr1_index) == a)) return bus.wr1_data;
    if (bus.wr0_en && (int'(bus.wr0_index) == a)) return bus.wr0_data;
    return m_mem[a];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_busy = '0;
      for (int p = 0; p < NRD; p++) m_haddr[p] = 0;
    end else begin
      for (int p = 0; p < NRD; p++)
        if (bus.rd_en[p]) m_haddr[p] = int'(bus.rd_index[p*AW +: AW]);
      if (bus.wr0_en && bus.wr0_index != 0) begin
        m_mem[bus.wr0_index] = bus.wr0_data;
        m_busy[bus.wr0_index] = 1'b0;
      end
      if (bus.wr1_en && bus.wr1_index != 0) begin
        m_mem[bus.wr1_index] = bus.wr1_data;
        m_busy[bus.wr1_index] = 1'b0;
      end
      if (bus.alloc_en && bus.alloc_index != 0) m_busy[bus.alloc_index] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("model_rd_data%0d", p), rd(p), exp_data(p), 1'b1);
        chk($sformatf("model_rd_busy%0d", p), XLEN'(bus.rd_busy[p]),
            XLEN'(m_haddr[p] != 0 && !wr_to(m_haddr[p]) && m_busy[m_haddr[p]]), 1'b1);
      end
      chk("model_busy_vec", bus.busy_vec, m_busy, 1'b1);
    end
  end

  task automatic idle();
    bus.wr0_en = 1'b0; bus.wr0_index = '0; bus.wr0_data = '0;
    bus.wr1_en = 1'b0; bus.wr1_index = '0; bus.wr1_data = '0;
    bus.rd_en = '0; bus.rd_index = '0;
    bus.alloc_en = 1'b0; bus.alloc_index = '0;
  endtask

  task automatic wr0(input int a, input logic [XLEN-1:0] d);
    bus.wr0_en = 1'b1; bus.wr0_index = AW'(a); bus.wr0_data = d;
  endtask

  task automatic wr1(input int a, input logic [XLEN-1:0] d);
    bus.wr1_en = 1'b1; bus.wr1_index = AW'(a); bus.wr1_data = d;
  endtask

  task automatic rdp(input int p, input int a);
    bus.rd_en[p] = 1'b1; bus.rd_index[p*AW +: AW] = AW'(a);
  endtask

  task automatic alloc(input int a);
    bus.alloc_en = 1'b1; bus.alloc_index = AW'(a);
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    #2 reset_n = 1'b0;
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    to_neg();
    chk("reset_rd_data0", rd(0), '0, 1'b0);
    chk("reset_rd_busy", XLEN'(bus.rd_busy), '0, 1'b0);
    chk("reset_busy_vec", bus.busy_vec, '0, 1'b0);
    to_next();
    reset_n = 1'b1;

    rdp(0, 7); rdp(1, 7);
    to_neg(); to_next();
    to_neg();
    chk("rd_x7_port0", rd(0), '0, 1'b0);
    chk("rd_x7_port1", rd(1), '0, 1'b0);
    chk("busy_vec_clear", bus.busy_vec, '0, 1'b0);
    to_next();

    wr0(5, 32'hDEADBEEF);
    to_neg(); to_next();
    rdp(0, 5);
    to_neg(); to_next();
    to_neg();
    chk("rd_x5", rd(0), 32'hDEADBEEF, 1'b0);
    to_next();

    rdp(0, 9);
    to_neg(); to_next();
    to_neg();
    chk("hold_x9_initial", rd(0), '0, 1'b0);
    to_next();
    wr0(9, 32'h1234);
    to_neg();
    chk("hold_x9_fwd", rd(0), 32'h1234, 1'b0);
    to_next();
    to_neg();
    chk("hold_x9_after1", rd(0), 32'h1234, 1'b0);
    to_next();
    to_neg();
    chk("hold_x9_after2", rd(0), 32'h1234, 1'b0);
    to_next();
    wr1(9, 32'h55);
    to_neg();
    chk("hold_x9_fwd2", rd(0), 32'h55, 1'b0);
    to_next();
    to_neg();
    chk("hold_x9_second", rd(0), 32'h55, 1'b0);
    to_next();

    wr0(3, 32'hAAAA); wr1(3, 32'hBBBB); rdp(1, 3);
    to_neg(); to_next();
    to_neg();
    chk("dual_write_x3", rd(1), 32'hBBBB, 1'b0);
    to_next();

    wr0(0, 32'hFFFF); alloc(0);
    to_neg(); to_next();
    rdp(0, 0);
    to_neg(); to_next();
    to_neg();
    chk("x0_read_zero", rd(0), '0, 1'b0);
    chk("x0_never_busy", XLEN'(bus.busy_vec[0]), '0, 1'b0);
    to_next();

    alloc(4); rdp(1, 4);
    to_neg(); to_next();
    to_neg();
    chk("alloc_x4_busy_vec", XLEN'(bus.busy_vec[4]), 32'd1, 1'b0);
    chk("alloc_x4_rd_busy", XLEN'(bus.rd_busy[1]), 32'd1, 1'b0);
    to_next();
    wr0(4, 32'h44);
    to_neg();
    chk("wr_x4_rd_busy_same", XLEN'(bus.rd_busy[1]), '0, 1'b0);
    chk("wr_x4_fwd", rd(1), 32'h44, 1'b0);
    to_next();
    to_neg();
    chk("wr_x4_busy_vec_next", XLEN'(bus.busy_vec[4]), '0, 1'b0);
    to_next();
    bus.wr0_index = AW'(4); bus.wr0_data = 32'h999;
    to_neg();
    chk("no_fwd_without_en", rd(1), 32'h44, 1'b0);
    to_next();

    alloc(6); wr1(6, 32'h66);
    to_neg(); to_next();
    to_neg();
    chk("alloc_wr_x6_busy", XLEN'(bus.busy_vec[6]), 32'd1, 1'b0);
    to_next();

    #2 reset_n = 1'b0;
    #1;
    chk("midreset_busy_vec", bus.busy_vec, '0, 1'b0);
    chk("midreset_rd_data1", rd(1), '0, 1'b0);
    to_neg(); to_next();
    reset_n = 1'b1;
    rdp(0, 5);
    to_neg(); to_next();
    to_neg();
    chk("post_reset_x5", rd(0), '0, 1'b0);
    to_next();

    for (int n = 0; n < 80; n++) begin
      bus.wr0_en      = 1'($urandom);
      bus.wr0_index   = AW'($urandom_range(0, 7));
      bus.wr0_data    = $urandom;
      bus.wr1_en      = 1'($urandom);
      bus.wr1_index   = AW'($urandom_range(0, 7));
      bus.wr1_data    = $urandom;
      bus.rd_en       = NRD'($urandom);
      bus.rd_index    = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      bus.alloc_en    = 1'($urandom);
      bus.alloc_index = AW'($urandom_range(0, 7));
      to_neg();
      to_next();
    end
    to_neg();
    run = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
